// File: rtl/noc_inject_arbiter_pkg.sv
// rtl/noc_inject_arbiter_pkg.sv - shared flit types and injection-arbiter constants
package noc_inject_arbiter_pkg;

  localparam int FLIT_DATA_SIZE   = 32;
  localparam int VC_NUM           = 2;
  localparam int VC_ID_W          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DEST_ADDR_SIZE_X = 2;
  localparam int DEST_ADDR_SIZE_Y = 2;
  localparam int INJ_ARB_N_REQ    = 4;
  localparam int INJ_ARB_STAT_W   = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t                flit_label;
    logic [VC_ID_W-1:0]         vc_id;
    logic [FLIT_DATA_SIZE-1:0]  data;
  } flit_t;

  localparam flit_t IDLE_FLIT = '{flit_label: HEADTAIL, vc_id: '0, data: '0};

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - requester and router-side bundle of the injection arbiter
interface noc_inject_arbiter_if #(
  parameter int N_REQ = noc_inject_arbiter_pkg::INJ_ARB_N_REQ,
  parameter int PTR_W = $clog2(N_REQ)
) ();
  import noc_inject_arbiter_pkg::*;

  logic [N_REQ-1:0]                req_valid;
  logic [2*N_REQ-1:0]              req_label;
  logic [N_REQ*FLIT_DATA_SIZE-1:0] req_data;
  logic [N_REQ-1:0]                req_ready;
  logic [VC_NUM-1:0]               router_is_on_off_out;
  logic [VC_NUM-1:0]               router_is_allocatable_out;
  flit_t                           router_data_in;
  logic                            router_valid_in;
  logic                            grant_vld;
  logic [PTR_W-1:0]                grant_idx;
  logic                            proto_err;

  modport master (
    output req_valid, req_label, req_data, router_is_on_off_out, router_is_allocatable_out,
    input  req_ready, router_data_in, router_valid_in, grant_vld, grant_idx, proto_err
  );

  modport slave (
    input  req_valid, req_label, req_data, router_is_on_off_out, router_is_allocatable_out,
    output req_ready, router_data_in, router_valid_in, grant_vld, grant_idx, proto_err
  );

endinterface

// File: rtl/noc_inject_arbiter_rr_pick_first.sv
// rtl/noc_inject_arbiter_rr_pick_first.sv - first set request bit at or after ptr, wrapping
module rr_pick_first #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             vld_o,
  output logic [PTR_W-1:0] idx_o
);

  always_comb begin
    int j;
    vld_o = 1'b0;
    idx_o = '0;
    j     = 0;
    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        vld_o = 1'b1;
        idx_o = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-locking round-robin arbiter onto one router injection port
// Optional per-requester packet counters when INJ_ARB_STATS_EN is defined.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int N_REQ = INJ_ARB_N_REQ
) (
  input  logic                 clk_router,
  input  logic                 rst_router,
  noc_inject_arbiter_if.slave  bus
`ifdef INJ_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [N_REQ*INJ_ARB_STAT_W-1:0] stat_pkt_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     grant_idx_q, grant_idx_d;
  logic [VC_ID_W-1:0]   vc_lock_q, vc_lock_d;
  flit_t                out_q, out_d;
  logic                 out_vld_q, out_vld_d;

  flit_label_t               lbl [N_REQ];
  logic [FLIT_DATA_SIZE-1:0] dat [N_REQ];
  logic [N_REQ-1:0]          head_cand, body_off, ready;
  logic                      pick_vld;
  logic [PTR_W-1:0]          pick_idx;
  logic                      vc_avail;
  logic [VC_ID_W-1:0]        vc_pick;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign lbl[g]       = flit_label_t'(bus.req_label[2*g +: 2]);
    assign dat[g]       = bus.req_data[FLIT_DATA_SIZE*g +: FLIT_DATA_SIZE];
    assign head_cand[g] = bus.req_valid[g] && (lbl[g] == HEAD || lbl[g] == HEADTAIL);
    assign body_off[g]  = bus.req_valid[g] && (lbl[g] == BODY || lbl[g] == TAIL);
  end

  rr_pick_first #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i (head_cand),
    .ptr_i (rr_ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_comb begin
    vc_avail = 1'b0;
    vc_pick  = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (bus.router_is_on_off_out[v] && bus.router_is_allocatable_out[v]) begin
        vc_avail = 1'b1;
        vc_pick  = VC_ID_W'(v);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    vc_lock_d   = vc_lock_q;
    ready       = '0;
    out_vld_d   = 1'b0;
    out_d       = IDLE_FLIT;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && vc_avail) begin
          ready[pick_idx]  = 1'b1;
          out_vld_d        = 1'b1;
          out_d.flit_label = lbl[pick_idx];
          out_d.vc_id      = vc_pick;
          out_d.data       = dat[pick_idx];
          if (lbl[pick_idx] == HEAD) begin
            state_d     = ST_LOCKED;
            grant_idx_d = pick_idx;
            vc_lock_d   = vc_pick;
          end else begin
            rr_ptr_d = next_ptr(pick_idx);
          end
        end
      end
      ST_LOCKED: begin
        // VC stays pinned for the packet; a credit drop only stalls.
        if (bus.req_valid[grant_idx_q] && bus.router_is_on_off_out[vc_lock_q]) begin
          ready[grant_idx_q] = 1'b1;
          out_vld_d          = 1'b1;
          out_d.flit_label   = lbl[grant_idx_q];
          out_d.vc_id        = vc_lock_q;
          out_d.data         = dat[grant_idx_q];
          if (lbl[grant_idx_q] == TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr(grant_idx_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_router or posedge rst_router) begin
    if (rst_router) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      vc_lock_q   <= '0;
      out_q       <= IDLE_FLIT;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      vc_lock_q   <= vc_lock_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
    end
  end

  assign bus.req_ready       = rst_router ? '0 : ready;
  assign bus.router_data_in  = out_q;
  assign bus.router_valid_in = out_vld_q;
  assign bus.grant_vld       = (state_q == ST_LOCKED);
  assign bus.grant_idx       = grant_idx_q;
  assign bus.proto_err       = !rst_router && (state_q == ST_IDLE) && (|body_off);

`ifdef INJ_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic                      inc;
    logic [INJ_ARB_STAT_W-1:0] cnt_q;
    assign inc = ready[g] && (lbl[g] == TAIL || lbl[g] == HEADTAIL);
    always_ff @(posedge clk_router or posedge rst_router) begin
      if (rst_router)                              cnt_q <= '0;
      else if (stat_clr)                           cnt_q <= '0;
      else if (inc && cnt_q != {INJ_ARB_STAT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
    assign stat_pkt_cnt[INJ_ARB_STAT_W*g +: INJ_ARB_STAT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - directed self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;
  import noc_inject_arbiter_pkg::*;

  localparam int N = 4;

  logic clk_router = 1'b0;
  logic rst_router;
  int   checks = 0;
  int   errors = 0;

  noc_inject_arbiter_if #(.N_REQ(N)) bus ();

`ifdef INJ_ARB_STATS_EN
  logic              stat_clr;
  logic [N*16-1:0]   stat_pkt_cnt;
`endif

  noc_inject_arbiter #(.N_REQ(N)) dut (
    .clk_router   (clk_router),
    .rst_router   (rst_router),
    .bus          (bus.slave)
`ifdef INJ_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_pkt_cnt (stat_pkt_cnt)
`endif
  );

  always #5 clk_router = ~clk_router;

  task automatic cyc();
    @(posedge clk_router);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input flit_label_t l, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_label[2*i +: 2] = l;
    bus.req_data[32*i +: 32] = d;
  endtask

  task automatic pulse_reset();
    rst_router = 1'b1;
    cyc();
    rst_router = 1'b0;
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic [VC_ID_W-1:0] vc, input logic [31:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.data       = d;
    return f;
  endfunction

  task automatic test_reset();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", bus.req_ready); end
    checks++; if (bus.router_valid_in !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", bus.router_valid_in); end
    checks++; if (bus.router_data_in !== IDLE_FLIT) begin errors++; $display("FAIL rst_rdata got %h exp %h", bus.router_data_in, IDLE_FLIT); end
    checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL rst_gvld got %b exp 0", bus.grant_vld); end
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL rst_gidx got %0d exp 0", bus.grant_idx); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b exp 0", bus.proto_err); end
    rst_router = 1'b0;
    bus.router_is_on_off_out      = 2'b01;
    bus.router_is_allocatable_out = 2'b01;
    set_req(1, 1'b1, HEAD, 32'hC0DE_0001);
    cyc();
    checks++; if (bus.grant_vld !== 1'b1) begin errors++; $display("FAIL midrst_lock got %b exp 1", bus.grant_vld); end
    set_req(1, 1'b1, BODY, 32'hC0DE_0002);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_ready_pre got %b exp 0010", bus.req_ready); end
    rst_router = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b exp 0000", bus.req_ready); end
    checks++; if (bus.router_valid_in !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0", bus.router_valid_in); end
    checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL midrst_gvld got %b exp 0", bus.grant_vld); end
    cyc();
    rst_router = 1'b0;
    set_req(1, 1'b0, HEADTAIL, 32'h0);
    cyc();
    checks++; if (bus.router_valid_in !== 1'b0) begin errors++; $display("FAIL midrst_after got %b exp 0", bus.router_valid_in); end
  endtask

  task automatic test_single_packet();
    flit_label_t lbls [5] = '{HEAD, BODY, BODY, BODY, TAIL};
    bus.router_is_on_off_out      = 2'b01;
    bus.router_is_allocatable_out = 2'b11;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, lbls[k], 32'hA000_0000 + k);
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL pkt_ready[%0d] got %b exp 0001", k, bus.req_ready); end
      cyc();
      checks++;
      if (bus.router_valid_in !== 1'b1 || bus.router_data_in !== mk(lbls[k], 1'b0, 32'hA000_0000 + k)) begin
        errors++; $display("FAIL pkt_flit[%0d] got v=%b %h exp v=1 %h", k, bus.router_valid_in, bus.router_data_in, mk(lbls[k], 1'b0, 32'hA000_0000 + k));
      end
      checks++; if (bus.grant_vld !== (k < 4)) begin errors++; $display("FAIL pkt_gvld[%0d] got %b exp %b", k, bus.grant_vld, (k < 4)); end
    end
    set_req(0, 1'b0, HEADTAIL, 32'h0);
    cyc();
    checks++; if (bus.router_valid_in !== 1'b0 || bus.router_data_in !== IDLE_FLIT) begin errors++; $display("FAIL pkt_idle got v=%b %h exp v=0 %h", bus.router_valid_in, bus.router_data_in, IDLE_FLIT); end
  endtask

  task automatic test_rr_headtail();
    int exp_g [4] = '{1, 2, 1, 2};
    logic [31:0] d;
    pulse_reset();
    bus.router_is_on_off_out      = 2'b01;
    bus.router_is_allocatable_out = 2'b01;
    set_req(1, 1'b1, HEADTAIL, 32'h1111_0001);
    set_req(2, 1'b1, HEADTAIL, 32'h2222_0002);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.req_ready !== 4'(1 << exp_g[k])) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, bus.req_ready, 4'(1 << exp_g[k])); end
      cyc();
      d = (exp_g[k] == 1) ? 32'h1111_0001 : 32'h2222_0002;
      checks++;
      if (bus.router_valid_in !== 1'b1 || bus.router_data_in !== mk(HEADTAIL, 1'b0, d)) begin
        errors++; $display("FAIL rr_flit[%0d] got v=%b %h exp v=1 %h", k, bus.router_valid_in, bus.router_data_in, mk(HEADTAIL, 1'b0, d));
      end
      checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL rr_gvld[%0d] got %b exp 0", k, bus.grant_vld); end
    end
    set_req(1, 1'b0, HEADTAIL, 32'h0);
    set_req(2, 1'b0, HEADTAIL, 32'h0);
    cyc();
  endtask

  task automatic test_onoff_stall();
    logic [1:0]   onoff [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    flit_label_t  lbls  [7] = '{HEAD, BODY, BODY, BODY, BODY, BODY, TAIL};
    logic [31:0]  dats  [7] = '{32'hB0, 32'hB1, 32'hB2, 32'hB2, 32'hB2, 32'hB2, 32'hB3};
    logic [3:0]   rdy   [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    logic         rv    [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         gv    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    flit_t        exp_f;
    pulse_reset();
    bus.router_is_allocatable_out = 2'b10;
    set_req(3, 1'b1, HEAD, 32'hE0);
    for (int k = 0; k < 7; k++) begin
      bus.router_is_on_off_out = onoff[k];
      set_req(0, 1'b1, lbls[k], dats[k]);
      #1;
      checks++; if (bus.req_ready !== rdy[k]) begin errors++; $display("FAIL stall_ready[%0d] got %b exp %b", k, bus.req_ready, rdy[k]); end
      cyc();
      exp_f = rv[k] ? mk(lbls[k], 1'b1, dats[k]) : IDLE_FLIT;
      checks++;
      if (bus.router_valid_in !== rv[k] || bus.router_data_in !== exp_f) begin
        errors++; $display("FAIL stall_flit[%0d] got v=%b %h exp v=%b %h", k, bus.router_valid_in, bus.router_data_in, rv[k], exp_f);
      end
      checks++; if (bus.grant_vld !== gv[k]) begin errors++; $display("FAIL stall_gvld[%0d] got %b exp %b", k, bus.grant_vld, gv[k]); end
    end
    set_req(0, 1'b0, HEADTAIL, 32'h0);
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wait_ready got %b exp 1000", bus.req_ready); end
    cyc();
    checks++; if (bus.router_valid_in !== 1'b1 || bus.router_data_in !== mk(HEAD, 1'b1, 32'hE0)) begin errors++; $display("FAIL wait_flit got v=%b %h exp v=1 %h", bus.router_valid_in, bus.router_data_in, mk(HEAD, 1'b1, 32'hE0)); end
    checks++; if (bus.grant_vld !== 1'b1 || bus.grant_idx !== 2'd3) begin errors++; $display("FAIL wait_grant got %b/%0d exp 1/3", bus.grant_vld, bus.grant_idx); end
    set_req(3, 1'b1, TAIL, 32'hE1);
    cyc();
    checks++; if (bus.router_data_in !== mk(TAIL, 1'b1, 32'hE1) || bus.grant_vld !== 1'b0) begin errors++; $display("FAIL wait_tail got %h g=%b exp %h g=0", bus.router_data_in, bus.grant_vld, mk(TAIL, 1'b1, 32'hE1)); end
    set_req(3, 1'b0, HEADTAIL, 32'h0);
    cyc();
  endtask

  task automatic test_proto_err();
    bus.router_is_on_off_out      = 2'b11;
    bus.router_is_allocatable_out = 2'b11;
    set_req(2, 1'b1, BODY, 32'hDEAD);
    #1;
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got %b exp 1", bus.proto_err); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL perr_ready got %b exp 0000", bus.req_ready); end
    cyc();
    checks++; if (bus.router_valid_in !== 1'b0) begin errors++; $display("FAIL perr_rvalid got %b exp 0", bus.router_valid_in); end
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL perr_held got %b exp 1", bus.proto_err); end
    set_req(2, 1'b0, BODY, 32'h0);
    #1;
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear got %b exp 0", bus.proto_err); end
    bus.router_is_allocatable_out = 2'b00;
    set_req(1, 1'b1, HEADTAIL, 32'h77);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL novc_ready got %b exp 0000", bus.req_ready); end
    cyc();
    checks++; if (bus.router_valid_in !== 1'b0) begin errors++; $display("FAIL novc_rvalid got %b exp 0", bus.router_valid_in); end
    bus.router_is_allocatable_out = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL vc1_ready got %b exp 0010", bus.req_ready); end
    cyc();
    checks++; if (bus.router_data_in !== mk(HEADTAIL, 1'b1, 32'h77)) begin errors++; $display("FAIL vc1_flit got %h exp %h", bus.router_data_in, mk(HEADTAIL, 1'b1, 32'h77)); end
    set_req(1, 1'b0, HEADTAIL, 32'h0);
    cyc();
  endtask

`ifdef INJ_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    bus.router_is_on_off_out      = 2'b01;
    bus.router_is_allocatable_out = 2'b01;
    set_req(1, 1'b1, HEADTAIL, 32'h5);
    cyc();
    cyc();
    cyc();
    set_req(1, 1'b0, HEADTAIL, 32'h0);
    checks++; if (stat_pkt_cnt[16 +: 16] !== 16'd3) begin errors++; $display("FAIL stat_cnt1 got %0d exp 3", stat_pkt_cnt[16 +: 16]); end
    checks++; if (stat_pkt_cnt[0 +: 16] !== 16'd0) begin errors++; $display("FAIL stat_cnt0 got %0d exp 0", stat_pkt_cnt[0 +: 16]); end
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    checks++; if (stat_pkt_cnt[16 +: 16] !== 16'd0) begin errors++; $display("FAIL stat_clr got %0d exp 0", stat_pkt_cnt[16 +: 16]); end
  endtask
`endif

  initial begin
    rst_router                    = 1'b1;
    bus.req_valid                 = '0;
    bus.req_label                 = '0;
    bus.req_data                  = '0;
    bus.router_is_on_off_out      = '0;
    bus.router_is_allocatable_out = '0;
`ifdef INJ_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    cyc();
    cyc();
    test_reset();
    test_single_packet();
    test_rr_headtail();
    test_onoff_stall();
    test_proto_err();
`ifdef INJ_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
